// File: rtl/seq_game_if.sv
// seq_game_if: bundle between the game controller / keypad side and the
// memory-game engine. master drives sequence, start and keys; slave drives
// tone, status and result outputs back.
interface seq_game_if #(
    parameter int NOTE_W     = 4,
    parameter int MAX_LEN    = 8,
    parameter int MAX_MISSES = 3
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int LIV_W = $clog2(MAX_MISSES + 1);

    logic                      seq_wr;
    logic [NOTE_W*MAX_LEN-1:0] seq_data;
    logic                      start;
    logic                      key_valid;
    logic [NOTE_W-1:0]         key_data;
    logic [NOTE_W-1:0]         piezo_out;
    logic [NOTE_W-1:0]         led_out;
    logic                      playing;
    logic                      await_input;
    logic                      miss;
    logic [LEN_W-1:0]          round_len;
    logic [IDX_W-1:0]          input_index;
    logic [LIV_W-1:0]          lives;
    logic                      game_win;
    logic                      game_over;

    modport master (
        output seq_wr, seq_data, start, key_valid, key_data,
        input  piezo_out, led_out, playing, await_input, miss,
        input  round_len, input_index, lives, game_win, game_over
    );

    modport slave (
        input  seq_wr, seq_data, start, key_valid, key_data,
        output piezo_out, led_out, playing, await_input, miss,
        output round_len, input_index, lives, game_win, game_over
    );
endinterface

// File: rtl/seq_game_engine.sv
// seq_game_engine: memory-game core. Plays a growing prefix of a stored note
// sequence, then checks the player's key presses note by note.
// Ports: clk, reset (async, active high), bus (seq_game_if.slave):
//   in  seq_wr/seq_data, start, key_valid/key_data
//   out piezo_out/led_out, playing, await_input, miss, round_len,
//       input_index, lives, game_win, game_over
// Optional: define SEQ_GAME_TIMEOUT_EN to treat TIMEOUT_TICKS idle ticks in
// WAIT_KEY as a wrong key.
module seq_game_engine #(
    parameter int NOTE_W        = 4,
    parameter int MAX_LEN       = 8,
    parameter int START_LEN     = 3,
    parameter int TICK_DIV      = 3,
    parameter int NOTE_TICKS    = 3,
    parameter int GAP_TICKS     = 1,
    parameter int MAX_MISSES    = 3,
    parameter int TIMEOUT_TICKS = 64
) (
    input logic       clk,
    input logic       reset,
    seq_game_if.slave bus
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int LIV_W = $clog2(MAX_MISSES + 1);
    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TCK_W = $clog2(NOTE_TICKS + GAP_TICKS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PLAY_ON,
        S_PLAY_OFF,
        S_WAIT_KEY,
        S_WIN,
        S_LOSE
    } state_t;

    state_t                    state, state_n;
    logic [NOTE_W*MAX_LEN-1:0] seq_q, seq_n;
    logic                      loaded, loaded_n;
    logic [PRE_W-1:0]          pre, pre_n;
    logic [TCK_W-1:0]          tcnt, tcnt_n;
    logic [IDX_W-1:0]          play_idx, play_idx_n;
    logic [IDX_W-1:0]          in_idx, in_idx_n;
    logic [LEN_W-1:0]          rlen, rlen_n;
    logic [LIV_W-1:0]          lives, lives_n;
    logic [NOTE_W-1:0]         tone, tone_n;
    logic                      miss, miss_n;
    logic                      win, win_n;
    logic                      over, over_n;

    logic [NOTE_W-1:0] notes [MAX_LEN];
    logic [IDX_W-1:0]  nxt_idx;
    logic              tick;
    logic              hit;
    logic              last_key;
    logic              last_play;
    logic              timeout;

    always_comb begin
        for (int i = 0; i < MAX_LEN; i++) begin
            notes[i] = seq_q[i*NOTE_W +: NOTE_W];
        end
    end

    assign tick      = (pre == PRE_W'(TICK_DIV - 1));
    assign nxt_idx   = play_idx + IDX_W'(1);
    assign hit       = (bus.key_data == notes[in_idx]);
    assign last_key  = (LEN_W'(in_idx) == rlen - LEN_W'(1));
    assign last_play = (LEN_W'(play_idx) == rlen - LEN_W'(1));

`ifdef SEQ_GAME_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_TICKS + 1);

    logic [TO_W-1:0] to_cnt;

    // Idle-tick counter; restarts on every press and outside WAIT_KEY.
    assign timeout = (state == S_WAIT_KEY) && !bus.key_valid && tick &&
                     (to_cnt == TO_W'(TIMEOUT_TICKS - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt <= '0;
        end else if (state != S_WAIT_KEY || bus.key_valid || timeout) begin
            to_cnt <= '0;
        end else if (tick) begin
            to_cnt <= to_cnt + TO_W'(1);
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            seq_q    <= '0;
            loaded   <= 1'b0;
            pre      <= '0;
            tcnt     <= '0;
            play_idx <= '0;
            in_idx   <= '0;
            rlen     <= '0;
            lives    <= '0;
            tone     <= '0;
            miss     <= 1'b0;
            win      <= 1'b0;
            over     <= 1'b0;
        end else begin
            state    <= state_n;
            seq_q    <= seq_n;
            loaded   <= loaded_n;
            pre      <= pre_n;
            tcnt     <= tcnt_n;
            play_idx <= play_idx_n;
            in_idx   <= in_idx_n;
            rlen     <= rlen_n;
            lives    <= lives_n;
            tone     <= tone_n;
            miss     <= miss_n;
            win      <= win_n;
            over     <= over_n;
        end
    end

    always_comb begin
        state_n    = state;
        seq_n      = seq_q;
        loaded_n   = loaded;
        pre_n      = tick ? '0 : pre + PRE_W'(1);
        tcnt_n     = tcnt;
        play_idx_n = play_idx;
        in_idx_n   = in_idx;
        rlen_n     = rlen;
        lives_n    = lives;
        tone_n     = tone;
        miss_n     = 1'b0;
        win_n      = win;
        over_n     = over;

        unique case (state)
            S_IDLE, S_WIN, S_LOSE: begin
                // A sequence write takes priority over a same-cycle start.
                if (bus.seq_wr) begin
                    seq_n    = bus.seq_data;
                    loaded_n = 1'b1;
                end else if (bus.start && loaded) begin
                    state_n    = S_PLAY_ON;
                    rlen_n     = LEN_W'(START_LEN);
                    lives_n    = LIV_W'(MAX_MISSES);
                    play_idx_n = '0;
                    in_idx_n   = '0;
                    win_n      = 1'b0;
                    over_n     = 1'b0;
                    tone_n     = notes[0];
                    pre_n      = '0;
                    tcnt_n     = '0;
                end
            end

            S_PLAY_ON: begin
                if (tick) begin
                    if (tcnt == TCK_W'(NOTE_TICKS - 1)) begin
                        state_n = S_PLAY_OFF;
                        tcnt_n  = '0;
                        tone_n  = '0;
                    end else begin
                        tcnt_n = tcnt + TCK_W'(1);
                    end
                end
            end

            S_PLAY_OFF: begin
                if (tick) begin
                    if (tcnt == TCK_W'(GAP_TICKS - 1)) begin
                        tcnt_n = '0;
                        if (last_play) begin
                            state_n  = S_WAIT_KEY;
                            in_idx_n = '0;
                        end else begin
                            state_n    = S_PLAY_ON;
                            play_idx_n = nxt_idx;
                            tone_n     = notes[nxt_idx];
                        end
                    end else begin
                        tcnt_n = tcnt + TCK_W'(1);
                    end
                end
            end

            S_WAIT_KEY: begin
                if (bus.key_valid) begin
                    tone_n = bus.key_data;
                end
                if (bus.key_valid && hit) begin
                    if (!last_key) begin
                        in_idx_n = in_idx + IDX_W'(1);
                    end else if (rlen == LEN_W'(MAX_LEN)) begin
                        state_n = S_WIN;
                        win_n   = 1'b1;
                        tone_n  = '0;
                    end else begin
                        rlen_n     = rlen + LEN_W'(1);
                        state_n    = S_PLAY_ON;
                        play_idx_n = '0;
                        in_idx_n   = '0;
                        tone_n     = notes[0];
                        pre_n      = '0;
                        tcnt_n     = '0;
                    end
                end else if (bus.key_valid || timeout) begin
                    miss_n  = 1'b1;
                    lives_n = lives - LIV_W'(1);
                    if (lives == LIV_W'(1)) begin
                        state_n = S_LOSE;
                        over_n  = 1'b1;
                        tone_n  = '0;
                    end else begin
                        state_n    = S_PLAY_ON;
                        play_idx_n = '0;
                        in_idx_n   = '0;
                        tone_n     = notes[0];
                        pre_n      = '0;
                        tcnt_n     = '0;
                    end
                end
            end

            default: state_n = S_IDLE;
        endcase
    end

    assign bus.piezo_out   = tone;
    assign bus.led_out     = tone;
    assign bus.playing     = (state == S_PLAY_ON) || (state == S_PLAY_OFF);
    assign bus.await_input = (state == S_WAIT_KEY);
    assign bus.miss        = miss;
    assign bus.round_len   = rlen;
    assign bus.input_index = in_idx;
    assign bus.lives       = lives;
    assign bus.game_win    = win;
    assign bus.game_over   = over;
endmodule
